purchase_controller: RTL and testbench



---
 rtl/unit_pkg.sv | 51 +++++
 rtl/purchase_controller_if.sv | 25 ++
 rtl/income_timer.sv | 20 ++
 rtl/purchase_controller.sv | 121 ++++++++++++
 tb/tb_purchase_controller.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/unit_pkg.sv
// Unit-type codes, default costs, controller state encoding and type/cost helpers
// shared by the purchase path.
package unit_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } unit_type_t;

    localparam int COST1_DEF = 10;
    localparam int COST2_DEF = 25;
    localparam int COST3_DEF = 50;

    localparam logic [2:0] ST_IDLE  = 3'd0,
                           ST_CHECK = 3'd1,
                           ST_ISSUE = 3'd2,
                           ST_HOLD  = 3'd3,
                           ST_COOL  = 3'd4;

    function automatic int unsigned cost_of(input unit_type_t t, input int unsigned c1,
                                            input int unsigned c2, input int unsigned c3);
        case (t)
            T1:      return c1;
            T2:      return c2;
            T3:      return c3;
            default: return 0;
        endcase
    endfunction

    // Only a single raised switch selects a type; anything else is invalid.
    function automatic unit_type_t decode_sel(input logic [2:0] sw);
        case (sw)
            3'b001:  return T1;
            3'b010:  return T2;
            3'b100:  return T3;
            default: return NONE;
        endcase
    endfunction

    function automatic logic [2:0] onehot_of(input unit_type_t t);
        case (t)
            T1:      return 3'b001;
            T2:      return 3'b010;
            T3:      return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/purchase_controller_if.sv
// Buy-request / spawn-command bundle between the player controls and the unit slots.
interface purchase_controller_if #(
    parameter int NUM_SLOTS = 4,
    parameter int GOLD_W    = 10
);
    logic                 buy_req;
    logic [2:0]           sel_sw;
    logic [NUM_SLOTS-1:0] slot_idle;
    logic                 kill_pulse;
    logic [NUM_SLOTS-1:0] purchase;
    logic [2:0]           unit_sw;
    logic [GOLD_W-1:0]    gold;
    logic                 busy;
    logic                 reject;

    modport master (
        output buy_req, sel_sw, slot_idle, kill_pulse,
        input  purchase, unit_sw, gold, busy, reject
    );

    modport slave (
        input  buy_req, sel_sw, slot_idle, kill_pulse,
        output purchase, unit_sw, gold, busy, reject
    );
endinterface

// File: rtl/income_timer.sv
// Free-running prescaler: one-cycle tick every PERIOD clocks, on the counter wrap.
module income_timer #(
    parameter int PERIOD = 50000000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(PERIOD - 1));

    always_ff @(posedge clk) begin
        if (reset)     cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/purchase_controller.sv
// Gold bookkeeping and buy FSM feeding spawn strobes to the lowest idle unit slot.
// Build option: define PURCHASE_REFUND_EN to refund units that never left idle.
module purchase_controller
    import unit_pkg::*;
#(
    parameter int NUM_SLOTS     = 4,
    parameter int GOLD_W        = 10,
    parameter int GOLD_MAX      = 999,
    parameter int START_GOLD    = 30,
    parameter int INCOME_PERIOD = 50000000,
    parameter int INCOME_AMT    = 5,
    parameter int BOUNTY_AMT    = 8,
    parameter int COST1         = COST1_DEF,
    parameter int COST2         = COST2_DEF,
    parameter int COST3         = COST3_DEF,
    parameter int COOLDOWN      = 4
) (
    input logic                 clk,
    input logic                 reset,
    purchase_controller_if.slave bus
);
    localparam int GW     = GOLD_W + 2;
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CCW    = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    logic [2:0]        state;
    logic              buy_q;
    logic [CCW-1:0]    cool_cnt;
    logic              reject_q;
    logic [GOLD_W-1:0] gold_q;
    unit_type_t        type_q;
    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_sel;
    logic [GW-1:0]     cost_w;
    logic [GW-1:0]     gold_sum;
    logic              tick;
    logic              buy_edge;
    logic              check_ok;
    logic              refund_now;

    function automatic logic [GOLD_W-1:0] sat_gold(input logic [GW-1:0] v);
        if (v > GW'(GOLD_MAX)) return GOLD_W'(GOLD_MAX);
        return v[GOLD_W-1:0];
    endfunction

    income_timer #(.PERIOD(INCOME_PERIOD)) u_income (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign buy_edge = bus.buy_req & ~buy_q;
    assign cost_w   = GW'(cost_of(type_q, COST1, COST2, COST3));
    // Affordability looks at the registered balance only, never this cycle's income.
    assign check_ok = (type_q != NONE) && ({2'b00, gold_q} >= cost_w) && (|bus.slot_idle);

    always_comb begin
        slot_sel = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (bus.slot_idle[i]) slot_sel = SLOT_W'(i);
    end

`ifdef PURCHASE_REFUND_EN
    assign refund_now = (state == ST_HOLD) && bus.slot_idle[slot_q];
`else
    assign refund_now = 1'b0;
`endif

    always_comb begin
        gold_sum = {2'b00, gold_q};
        if (state == ST_CHECK && check_ok) gold_sum = gold_sum - cost_w;
        if (refund_now)                    gold_sum = gold_sum + cost_w;
        if (tick)                          gold_sum = gold_sum + GW'(INCOME_AMT);
        if (bus.kill_pulse)                gold_sum = gold_sum + GW'(BOUNTY_AMT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            buy_q    <= 1'b0;
            cool_cnt <= '0;
            reject_q <= 1'b0;
            gold_q   <= GOLD_W'(START_GOLD);
        end else begin
            buy_q    <= bus.buy_req;
            gold_q   <= sat_gold(gold_sum);
            reject_q <= (state == ST_CHECK && !check_ok) || refund_now;
            case (state)
                ST_IDLE:  if (buy_edge) state <= ST_CHECK;
                ST_CHECK: state <= check_ok ? ST_ISSUE : ST_IDLE;
                ST_ISSUE: state <= ST_HOLD;
                ST_HOLD: begin
                    cool_cnt <= '0;
                    state    <= (COOLDOWN == 0) ? ST_IDLE : ST_COOL;
                end
                ST_COOL: begin
                    if (cool_cnt == CCW'(COOLDOWN - 1)) state <= ST_IDLE;
                    else                                cool_cnt <= cool_cnt + CCW'(1);
                end
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Type is captured with the accepted edge; the slot is frozen in CHECK.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && buy_edge) type_q <= decode_sel(bus.sel_sw);
        if (state == ST_CHECK)            slot_q <= slot_sel;
    end

    always_comb begin
        bus.purchase = '0;
        if (state == ST_ISSUE) bus.purchase[slot_q] = 1'b1;
    end

    assign bus.unit_sw = (state == ST_ISSUE || state == ST_HOLD) ? onehot_of(type_q) : 3'b000;
    assign bus.gold    = gold_q;
    assign bus.busy    = (state != ST_IDLE);
    assign bus.reject  = reject_q;

endmodule

// File: tb/tb_purchase_controller.sv
// Bench for purchase_controller: transaction-timeline reference model checked every cycle,
// plus directed scenarios with hand-computed values.
module tb_purchase_controller;
    localparam int NS    = 4;
    localparam int GW    = 10;
    localparam int P     = 10;
    localparam int SG    = 30;
    localparam int CD    = 2;
    localparam int GMAX  = 999;
    localparam int INC   = 5;
    localparam int BNT   = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    purchase_controller_if #(.NUM_SLOTS(NS), .GOLD_W(GW)) bus ();

    purchase_controller #(
        .INCOME_PERIOD (P),
        .START_GOLD    (SG),
        .COOLDOWN      (CD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: one buy transaction at a time, located on a cycle timeline.
    logic m_valid = 1'b0;
    int   m_cyc, m_edge, m_slot, m_type, m_gold, m_refund_at;
    logic m_ok, m_buy_prev;
    int   c, g;
    logic edge_now;

    function automatic int cost_m(input int t);
        case (t)
            1: return 10;
            2: return 25;
            3: return 50;
            default: return 0;
        endcase
    endfunction

    function automatic int type_m(input logic [2:0] s);
        if (s == 3'b001) return 1;
        if (s == 3'b010) return 2;
        if (s == 3'b100) return 3;
        return 0;
    endfunction

    function automatic logic m_busy(input int k);
        if (m_edge < 0) return 1'b0;
        return (k >= m_edge + 1) && (k <= m_edge + (m_ok ? 3 + CD : 1));
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1; m_cyc = 0; m_edge = -1; m_ok = 1'b0; m_slot = 0; m_type = 0;
            m_gold = SG; m_buy_prev = 1'b0; m_refund_at = -1;
        end else if (m_valid) begin
            c = m_cyc;
            edge_now = bus.buy_req && !m_buy_prev;
            m_buy_prev = bus.buy_req;
            g = m_gold;
            if (m_edge >= 0 && c == m_edge + 1) begin
                m_slot = -1;
                for (int i = NS - 1; i >= 0; i--) if (bus.slot_idle[i]) m_slot = i;
                m_ok = (m_type != 0) && (m_gold >= cost_m(m_type)) && (m_slot >= 0);
                if (m_ok) g = g - cost_m(m_type);
            end
`ifdef PURCHASE_REFUND_EN
            if (m_edge >= 0 && m_ok && c == m_edge + 3 && bus.slot_idle[m_slot]) begin
                g = g + cost_m(m_type);
                m_refund_at = c + 1;
            end
`endif
            if (c % P == P - 1) g = g + INC;
            if (bus.kill_pulse) g = g + BNT;
            if (g > GMAX) g = GMAX;
            m_gold = g;
            if (edge_now && !m_busy(c)) begin
                m_edge = c;
                m_type = type_m(bus.sel_sw);
                m_ok   = 1'b0;
            end
            m_cyc = c + 1;
        end
    end

    int k;
    logic [3:0] e_p;
    logic [2:0] e_sw;
    logic       e_rej;
    always @(negedge clk) begin
        if (m_valid) begin
            k = m_cyc;
            e_p  = (m_edge >= 0 && m_ok && k == m_edge + 2) ? 4'(1 << m_slot) : 4'b0000;
            e_sw = 3'b000;
            if (m_edge >= 0 && m_ok && (k == m_edge + 2 || k == m_edge + 3))
                e_sw = 3'(1 << (m_type - 1));
            e_rej = (m_edge >= 0 && !m_ok && k == m_edge + 2) || (k == m_refund_at);
            chk("purchase", 32'(bus.purchase), 32'(e_p));
            chk("unit_sw",  32'(bus.unit_sw),  32'(e_sw));
            chk("gold",     32'(bus.gold),     32'(m_gold));
            chk("busy",     32'(bus.busy),     32'(m_busy(k)));
            chk("reject",   32'(bus.reject),   32'(e_rej));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Leaves the bench at cycle 0 after reset, inputs idle.
    task automatic do_reset();
        reset = 1'b1;
        bus.buy_req = 1'b0;
        bus.kill_pulse = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected end within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.buy_req = 1'b0; bus.sel_sw = 3'b001; bus.slot_idle = 4'b1111; bus.kill_pulse = 1'b0;
        step();
        do_reset();
        chk("rst_purchase", 32'(bus.purchase), 32'd0);
        chk("rst_unit_sw",  32'(bus.unit_sw),  32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_reject",   32'(bus.reject),   32'd0);
        chk("rst_gold",     32'(bus.gold),     32'd30);

        // Normal buy: edge at cycle 5, purchase at 7.
        bus.sel_sw = 3'b001; bus.slot_idle = 4'b1111;
        step_n(5);
        bus.buy_req = 1'b1;
        step_n(2);
        chk("t1_purchase", 32'(bus.purchase), 32'h1);
        chk("t1_unit_sw",  32'(bus.unit_sw),  32'h1);
        chk("t1_gold",     32'(bus.gold),     32'd20);
        step();
        chk("t1_hold_sw",  32'(bus.unit_sw),  32'h1);
        chk("t1_hold_p",   32'(bus.purchase), 32'h0);
        bus.buy_req = 1'b0;
        step_n(6);
        chk("t1_idle",     32'(bus.busy),     32'd0);
        chk("t1_income",   32'(bus.gold),     32'd25);

        // Slot priority.
        do_reset();
        bus.sel_sw = 3'b010; bus.slot_idle = 4'b1010;
        step();
        bus.buy_req = 1'b1;
        step_n(2);
        chk("t4_purchase", 32'(bus.purchase), 32'h2);
        chk("t4_gold",     32'(bus.gold),     32'd5);
        bus.buy_req = 1'b0;
        step_n(6);

        // Unaffordable, invalid type, full field.
        do_reset();
        bus.sel_sw = 3'b100; bus.slot_idle = 4'b1111;
        step();
        bus.buy_req = 1'b1;
        step_n(2);
        chk("t2_reject",   32'(bus.reject),   32'd1);
        chk("t2_purchase", 32'(bus.purchase), 32'd0);
        chk("t2_gold",     32'(bus.gold),     32'd30);
        chk("t2_busy",     32'(bus.busy),     32'd0);
        bus.buy_req = 1'b0;
        step();
        bus.sel_sw = 3'b011; bus.buy_req = 1'b1;
        step_n(2);
        chk("t3_inv_reject", 32'(bus.reject), 32'd1);
        chk("t3_inv_gold",   32'(bus.gold),   32'd30);
        bus.buy_req = 1'b0;
        step();
        bus.sel_sw = 3'b001; bus.slot_idle = 4'b0000; bus.buy_req = 1'b1;
        step_n(2);
        chk("t3_full_reject", 32'(bus.reject), 32'd1);
        chk("t3_full_gold",   32'(bus.gold),   32'd30);
        bus.buy_req = 1'b0;
        step_n(2);

        // Reset during ISSUE.
        do_reset();
        bus.sel_sw = 3'b001; bus.slot_idle = 4'b1111;
        step();
        bus.buy_req = 1'b1;
        step_n(2);
        chk("t6_issue_p", 32'(bus.purchase), 32'h1);
        chk("t6_issue_g", 32'(bus.gold),     32'd20);
        bus.buy_req = 1'b0;
        do_reset();
        chk("t6_rst_p",    32'(bus.purchase), 32'd0);
        chk("t6_rst_gold", 32'(bus.gold),     32'd30);
        chk("t6_rst_busy", 32'(bus.busy),     32'd0);

        // Slot stays idle through HOLD.
        bus.sel_sw = 3'b001; bus.slot_idle = 4'b1111;
        step();
        bus.buy_req = 1'b1;
        step_n(4);
`ifdef PURCHASE_REFUND_EN
        chk("refund_reject", 32'(bus.reject), 32'd1);
        chk("refund_gold",   32'(bus.gold),   32'd30);
`else
        chk("norefund_reject", 32'(bus.reject), 32'd0);
        chk("norefund_gold",   32'(bus.gold),   32'd20);
`endif
        bus.buy_req = 1'b0;
        step_n(6);

        // Saturation via kills and income, then a buy edge during COOL.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.kill_pulse = 1'($urandom_range(0, 1));
            step();
        end
        bus.kill_pulse = 1'b0;
        chk("t5_sat_gold", 32'(bus.gold), 32'd999);
        bus.sel_sw = 3'b001; bus.slot_idle = 4'b1111; bus.buy_req = 1'b1;
        step_n(2);
        chk("t5_purchase", 32'(bus.purchase), 32'h1);
        bus.buy_req = 1'b0;
        step_n(2);
        chk("t5_cool_busy", 32'(bus.busy), 32'd1);
        bus.buy_req = 1'b1;
        step_n(2);
        chk("t5_cool_rej", 32'(bus.reject),   32'd0);
        chk("t5_cool_p",   32'(bus.purchase), 32'd0);
        step();
        chk("t5_cool_idle", 32'(bus.busy),    32'd0);
        bus.buy_req = 1'b0;

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 2) == 0) bus.buy_req = ~bus.buy_req;
            if ($urandom_range(0, 4) == 0) bus.sel_sw = 3'($urandom_range(0, 7));
            else begin
                case ($urandom_range(0, 2))
                    0: bus.sel_sw = 3'b001;
                    1: bus.sel_sw = 3'b010;
                    default: bus.sel_sw = 3'b100;
                endcase
            end
            if ($urandom_range(0, 3) == 0) bus.slot_idle = 4'($urandom_range(0, 15));
            bus.kill_pulse = ($urandom_range(0, 5) == 0);
            step();
        end
        reset = 1'b0;
        bus.buy_req = 1'b0;
        bus.kill_pulse = 1'b0;
        step_n(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
